gpio_config_writer: RTL and testbench
=====================================

Name: gpio_config_writer

Overview:
- Host-to-PL end of the RPSPMC GPIO configuration path.
- PS writes 32-bit words over GPIO into a shadow buffer, then commits them with a target module address.
- The block drives the shared config_addr/config_data bus for a fixed number of cycles, then returns config_addr to 0.
- Commits to readback-range addresses are held on config_addr with no data strobe, so the readback mux can serve them.

Parameters:
NUM_WORDS, 16, number of 32-bit shadow words; config_data width is 32*NUM_WORDS.
HOLD_CYCLES, 4, cycles config_addr/config_valid are asserted per data commit (≥1).
GUARD_CYCLES, 2, cycles config_addr is forced to 0 after a data commit (≥1).
RB_ADDR_MIN, 100000, lowest readback address (inclusive).
RB_ADDR_MAX, 199999, highest readback address (inclusive).

Ports:
aclk  in  1  clock, all logic on rising edge.
aresetn  in  1  synchronous active-low reset.
gpio_ctrl  in  32  [31] wr toggle, [30] commit toggle, [29] error-clear toggle, [7:0] word index, rest reserved.
gpio_addr  in  32  target module address, sampled on commit.
gpio_data  in  32  shadow word, sampled on wr event.
config_addr  out  32  address broadcast to module config decoders.
config_data  out  32*NUM_WORDS  committed payload; word k at bits [32k+31:32k].
config_valid  out  1  high while a data commit is published.
gpio_status  out  32  [0] wr ack, [1] commit ack, [2] busy, [3] pending, [4] idx_err, [5] addr0_err, [15:8] overrun count, [31:16] sequence count (see optional feature).

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - All outputs 0, shadow words 0, state IDLE, pending cleared, counters 0.
  - Toggle-history registers load the current gpio_ctrl[31:29], so there is no spurious event at reset release.
- Event detection:
  - Event = gpio_ctrl bit differs from its history register.
  - History updates every cycle.
  - Event seen at edge n takes effect at edge n+1.
- Wr event:
  - If idx < NUM_WORDS, shadow[idx] <= gpio_data.
  - Otherwise the write is ignored and idx_err is set (sticky).
  - In both cases status[0] <= gpio_ctrl[31].
  - Writes are accepted in any state; config_data is unaffected until the next commit.
- Error-clear event: clears idx_err, addr0_err and the overrun count. It has priority over a same-cycle error set.
- Commit event in IDLE, with A = gpio_addr:
  - A == 0: addr0_err set, status[1] <= commit toggle, no bus activity.
  - RB_ADDR_MIN ≤ A ≤ RB_ADDR_MAX:
    - config_addr <= A and is held indefinitely.
    - config_valid stays 0; config_data is unchanged.
    - status[1] updates; stay IDLE.
  - Otherwise (data commit):
    - config_addr <= A and config_data <= shadow.
    - A wr event in the same cycle is included in the committed data.
    - config_valid <= 1; go to HOLD.
- HOLD:
  - Lasts HOLD_CYCLES cycles.
  - Then config_addr <= 0 and config_valid <= 0; go to GUARD.
- GUARD:
  - Lasts GUARD_CYCLES cycles.
  - Then IDLE; status[1] <= latched commit toggle.
  - config_data stays held until the next data commit.
- busy = (state != IDLE).
- Commit event while busy:
  - Latched into a one-deep pending slot (address + toggle value); pending=1.
  - It launches on the first IDLE cycle, using the then-current shadow contents.
  - A further commit while pending is dropped; overrun count increments, saturating at 255, and its ack is never given.
- Reset mid-HOLD or mid-GUARD: immediate return to the reset state; config_addr=0 on the next cycle.

Optional Feature:
CONFIG_WRITER_SEQCOUNT_EN:
- Defined: a 16-bit counter increments, wrapping, on every completed commit of any kind (data, readback or addr0). Its value is exposed on gpio_status[31:16]; it is cleared only by reset.
- Undefined: gpio_status[31:16] is constant 0 and no counter logic is present.

Test Plan:
1. Data commit: write words 0..15 with values 0x1000+k, then commit addr 5000 -> config_addr=5000 and config_valid=1 for exactly 4 cycles starting edge n+1; config_data word 3 = 0x1003; then addr 0 for 2 cycles; status[1] flips at n+7.
2. Readback hold: commit addr 100001 -> config_addr=100001 held for 100 cycles, config_valid never 1, config_data unchanged, ack after 1 cycle.
3. Busy overlap: commit 6000, then commit 7000 during HOLD and a third commit during HOLD -> 7000 published right after GUARD, overrun=1, pending clears on launch.
4. Boundary: write idx 16 -> shadow unchanged, idx_err=1; commit addr 0 -> addr0_err=1, no bus activity; error-clear toggle -> status[5:4]=0 and overrun=0.
5. Simultaneous wr (idx 2, 0xDEAD) and commit in the same cycle -> committed word 2 = 0xDEAD.
6. aresetn low during HOLD -> config_addr=0 and valid=0 next cycle; with gpio_ctrl[31]=1 at release, no wr event fires; with SEQCOUNT_EN, status[31:16]=0.

Source files
------------

// File: rtl/gpio_config_writer.sv
// gpio_config_writer: PS-to-PL configuration writer for the RPSPMC GPIO path.
// The PS fills a shadow buffer word by word over GPIO, then commits it with a
// target address. Data commits are published on config_addr/config_data with
// config_valid for HOLD_CYCLES, followed by GUARD_CYCLES of address 0.
// Readback-range commits park the address on config_addr with no data strobe.
// A commit that arrives while busy waits in a one-deep pending slot.
// Handshake: every host action is a toggle on a gpio_ctrl bit. An action is
// detected when the bit differs from its one-cycle history. It is executed one
// edge later, and it is acknowledged by mirroring the toggle value into gpio_status.
// Optional build macro: CONFIG_WRITER_SEQCOUNT_EN adds a 16-bit
// completed-commit counter on gpio_status[31:16].
module gpio_config_writer #(
   parameter int          NUM_WORDS    = 16,
   parameter int          HOLD_CYCLES  = 4,
   parameter int          GUARD_CYCLES = 2,
   parameter logic [31:0] RB_ADDR_MIN  = 32'd100000,
   parameter logic [31:0] RB_ADDR_MAX  = 32'd199999
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [31:0]             gpio_ctrl,
   input  logic [31:0]             gpio_addr,
   input  logic [31:0]             gpio_data,
   output logic [31:0]             config_addr,
   output logic [32*NUM_WORDS-1:0] config_data,
   output logic                    config_valid,
   output logic [31:0]             gpio_status
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GUARD} state_t;

   state_t                     r_state, w_state_nxt;
   logic [2:0]                 r_hist;
   logic                       r_wr_ev, r_cm_ev, r_clr_ev, r_wr_tog, r_cm_tog;
   logic [7:0]                 r_idx;
   logic [31:0]                r_data, r_addr;
   logic [NUM_WORDS-1:0][31:0] r_shadow, w_shadow_nxt;
   logic [15:0]                r_cnt;
   logic                       r_pend, r_pend_tog, r_cur_tog;
   logic [31:0]                r_pend_addr;
   logic                       r_wr_ack, r_cm_ack, r_idx_err, r_a0_err;
   logic [7:0]                 r_ovr;
   logic                       w_idle, w_use_pend, w_go, w_go_tog;
   logic [31:0]                w_go_addr;
   logic                       w_is_a0, w_is_rb, w_is_data, w_queue, w_overrun;
   logic                       w_hold_done, w_guard_done;
   logic [15:0]                w_seq;
   logic                       w_unused_ctrl;

   assign w_unused_ctrl = ^gpio_ctrl[28:8];

   // Toggle detection: history follows gpio_ctrl every cycle (also in reset),
   // and the detected events are registered together with their operands.
   always_ff @(posedge aclk) begin
      r_hist <= gpio_ctrl[31:29];
      if (!aresetn) begin
         r_wr_ev  <= 1'b0;
         r_cm_ev  <= 1'b0;
         r_clr_ev <= 1'b0;
         r_wr_tog <= 1'b0;
         r_cm_tog <= 1'b0;
         r_idx    <= '0;
         r_data   <= '0;
         r_addr   <= '0;
      end else begin
         r_wr_ev  <= gpio_ctrl[31] ^ r_hist[2];
         r_cm_ev  <= gpio_ctrl[30] ^ r_hist[1];
         r_clr_ev <= gpio_ctrl[29] ^ r_hist[0];
         r_wr_tog <= gpio_ctrl[31];
         r_cm_tog <= gpio_ctrl[30];
         r_idx    <= gpio_ctrl[7:0];
         r_data   <= gpio_data;
         r_addr   <= gpio_addr;
      end
   end

   // Commit decode: a pending commit launches before a fresh one; a fresh one
   // that cannot launch now is queued, or dropped when the slot stays full.
   always_comb begin
      w_idle       = (r_state == ST_IDLE);
      w_use_pend   = w_idle && r_pend;
      w_go         = w_idle && (r_pend || r_cm_ev);
      w_go_addr    = w_use_pend ? r_pend_addr : r_addr;
      w_go_tog     = w_use_pend ? r_pend_tog : r_cm_tog;
      w_is_a0      = w_go && (w_go_addr == 32'd0);
      w_is_rb      = w_go && (w_go_addr >= RB_ADDR_MIN) && (w_go_addr <= RB_ADDR_MAX);
      w_is_data    = w_go && !w_is_a0 && !w_is_rb;
      w_queue      = r_cm_ev && !(w_idle && !r_pend);
      w_overrun    = w_queue && r_pend && !w_use_pend;
      w_hold_done  = (r_state == ST_HOLD) && (r_cnt == 16'(HOLD_CYCLES - 1));
      w_guard_done = (r_state == ST_GUARD) && (r_cnt == 16'(GUARD_CYCLES - 1));
      // A same-cycle word write is folded in so a commit captures it.
      w_shadow_nxt = r_shadow;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (r_wr_ev && (32'(r_idx) == k)) w_shadow_nxt[k] = r_data;
      end
   end

   // Next-state logic for the publish sequence IDLE -> HOLD -> GUARD -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_is_data)    w_state_nxt = ST_HOLD;
         ST_HOLD:  if (w_hold_done)  w_state_nxt = ST_GUARD;
         ST_GUARD: if (w_guard_done) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   // State, shadow buffer, pending slot, bus outputs and status flags.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state      <= ST_IDLE;
         r_shadow     <= '0;
         r_cnt        <= '0;
         r_pend       <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_tog   <= 1'b0;
         r_cur_tog    <= 1'b0;
         config_addr  <= '0;
         config_data  <= '0;
         config_valid <= 1'b0;
         r_wr_ack     <= 1'b0;
         r_cm_ack     <= 1'b0;
         r_idx_err    <= 1'b0;
         r_a0_err     <= 1'b0;
         r_ovr        <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         if (w_state_nxt != r_state) r_cnt <= '0;
         else if (!w_idle)           r_cnt <= r_cnt + 16'd1;

         if (w_queue && !w_overrun) begin
            r_pend      <= 1'b1;
            r_pend_addr <= r_addr;
            r_pend_tog  <= r_cm_tog;
         end else if (w_use_pend) begin
            r_pend <= 1'b0;
         end

         if (w_is_data) begin
            config_addr  <= w_go_addr;
            config_data  <= w_shadow_nxt;
            config_valid <= 1'b1;
            r_cur_tog    <= w_go_tog;
         end else if (w_is_rb) begin
            config_addr <= w_go_addr;
         end else if (w_hold_done) begin
            config_addr  <= '0;
            config_valid <= 1'b0;
         end

         if (r_wr_ev) r_wr_ack <= r_wr_tog;
         if (w_is_a0 || w_is_rb) r_cm_ack <= w_go_tog;
         else if (w_guard_done)  r_cm_ack <= r_cur_tog;

         // Error clear wins over any error raised in the same cycle.
         if (r_clr_ev) begin
            r_idx_err <= 1'b0;
            r_a0_err  <= 1'b0;
            r_ovr     <= '0;
         end else begin
            if (r_wr_ev && (32'(r_idx) >= NUM_WORDS)) r_idx_err <= 1'b1;
            if (w_is_a0)                              r_a0_err  <= 1'b1;
            if (w_overrun && (r_ovr != 8'hFF))        r_ovr     <= r_ovr + 8'd1;
         end
      end
   end

`ifdef CONFIG_WRITER_SEQCOUNT_EN
   logic [15:0] r_seq;
   logic        w_done;
   assign w_done = w_guard_done || w_is_a0 || w_is_rb;

   // Completed-commit counter, wraps, cleared only by reset.
   always_ff @(posedge aclk) begin
      if (!aresetn)    r_seq <= '0;
      else if (w_done) r_seq <= r_seq + 16'd1;
   end
   assign w_seq = r_seq;
`else
   assign w_seq = '0;
`endif

   assign gpio_status = {w_seq, r_ovr, 2'b00, r_a0_err, r_idx_err,
                         r_pend, ~w_idle, r_cm_ack, r_wr_ack};

endmodule

// File: tb/tb_gpio_config_writer.sv
// Testbench for gpio_config_writer: directed scenarios plus randomized
// write/commit/clear traffic, with bus changes checked against an expected queue.
module tb_gpio_config_writer;
   localparam int          NW     = 16;
   localparam int          HOLD   = 4;
   localparam int          GUARD  = 2;
   localparam int          DW     = 32 * NW;
   localparam int          EW     = 32 + 32 + 1 + DW;
   localparam logic [31:0] RB_MIN = 32'd100000;
   localparam logic [31:0] RB_MAX = 32'd199999;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [31:0]   gpio_ctrl = '0;
   logic [31:0]   gpio_addr = '0;
   logic [31:0]   gpio_data = '0;
   logic [31:0]   config_addr;
   logic [DW-1:0] config_data;
   logic          config_valid;
   logic [31:0]   gpio_status;
   int            cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gpio_config_writer #(
      .NUM_WORDS(NW), .HOLD_CYCLES(HOLD), .GUARD_CYCLES(GUARD),
      .RB_ADDR_MIN(RB_MIN), .RB_ADDR_MAX(RB_MAX)
   ) dut (
      .aclk(clk), .aresetn(rstn), .gpio_ctrl(gpio_ctrl), .gpio_addr(gpio_addr),
      .gpio_data(gpio_data), .config_addr(config_addr), .config_data(config_data),
      .config_valid(config_valid), .gpio_status(gpio_status)
   );

   // ---------------- reference model ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [EW-1:0] exp_q[$];
   logic [31:0]   m_shadow[NW];
   logic [DW-1:0] m_cfg = '0;
   logic [31:0]   m_addr = '0;
   logic          m_wr_ack = 1'b0, m_cm_ack = 1'b0, m_idx_err = 1'b0, m_a0_err = 1'b0;
   logic [7:0]    m_ovr = '0;
   logic [15:0]   m_seq = '0;

   function automatic logic [DW-1:0] snap();
      logic [DW-1:0] s;
      for (int k = 0; k < NW; k++) s[32*k +: 32] = m_shadow[k];
      return s;
   endfunction

   function automatic logic [31:0] m_status();
      logic [15:0] s;
      s = '0;
`ifdef CONFIG_WRITER_SEQCOUNT_EN
      s = m_seq;
`endif
      return {s, m_ovr, 2'b00, m_a0_err, m_idx_err, 1'b0, 1'b0, m_cm_ack, m_wr_ack};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NW; k++) m_shadow[k] = '0;
      m_cfg = '0; m_addr = '0; m_wr_ack = 0; m_cm_ack = 0;
      m_idx_err = 0; m_a0_err = 0; m_ovr = '0; m_seq = '0;
   endtask

   task automatic push_rec(input int stamp, input logic [31:0] a, input logic v,
                           input logic [DW-1:0] d);
      exp_q.push_back({32'(stamp), a, v, d});
   endtask

   task automatic model_wr(input logic [7:0] idx, input logic [31:0] d);
      int i;
      i = int'(idx);
      if (i < NW) m_shadow[i] = d;
      else        m_idx_err = 1'b1;
      m_wr_ack = gpio_ctrl[31];
   endtask

   // Commit seen by the DUT at edge n: published bus changes and final status.
   task automatic model_commit(input logic [31:0] a, input int n, input logic tog);
      if (a == 32'd0) begin
         m_a0_err = 1'b1;
      end else if (a >= RB_MIN && a <= RB_MAX) begin
         if (m_addr != a) push_rec(n + 1, a, 1'b0, m_cfg);
         m_addr = a;
      end else begin
         m_cfg = snap();
         push_rec(n + 1, a, 1'b1, m_cfg);
         push_rec(n + 1 + HOLD, 32'd0, 1'b0, m_cfg);
         m_addr = '0;
      end
      m_cm_ack = tog;
      m_seq++;
   endtask

   // ---------------- scoreboard helpers / monitor ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   logic [31:0]   prev_addr = '0;
   logic          prev_valid = 1'b0;
   logic [EW-1:0] mon_got, mon_exp;

   always @(negedge clk) begin
      if (config_addr !== prev_addr || config_valid !== prev_valid) begin
         mon_got = {32'(cyc), config_addr, config_valid, config_data};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL bus_unexpected: got cyc=%0d addr=%0d valid=%0b, expected no change",
                     cyc, config_addr, config_valid);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_bad++;
               $display("FAIL bus: got cyc=%0d addr=%0d v=%0b data=%h expected cyc=%0d addr=%0d v=%0b data=%h",
                        mon_got[EW-1 -: 32], mon_got[EW-33 -: 32], mon_got[DW], mon_got[DW-1:0],
                        mon_exp[EW-1 -: 32], mon_exp[EW-33 -: 32], mon_exp[DW], mon_exp[DW-1:0]);
            end
         end
      end
      prev_addr  <= config_addr;
      prev_valid <= config_valid;
   end

   // ---------------- driver tasks (called at negedge) ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_wr(input logic [7:0] idx, input logic [31:0] d);
      gpio_ctrl[7:0] = idx;
      gpio_data      = d;
      gpio_ctrl[31]  = ~gpio_ctrl[31];
      model_wr(idx, d);
      @(negedge clk);
   endtask

   task automatic do_clear();
      gpio_ctrl[29] = ~gpio_ctrl[29];
      m_idx_err = 1'b0; m_a0_err = 1'b0; m_ovr = '0;
      @(negedge clk);
   endtask

   task automatic drive_commit(input logic [31:0] a, input bit with_wr, input logic [7:0] idx,
                               input logic [31:0] d, output int n, output logic tog);
      n = cyc + 1;
      gpio_addr     = a;
      gpio_ctrl[30] = ~gpio_ctrl[30];
      tog           = gpio_ctrl[30];
      if (with_wr) begin
         gpio_ctrl[7:0] = idx;
         gpio_data      = d;
         gpio_ctrl[31]  = ~gpio_ctrl[31];
         model_wr(idx, d);
      end
      @(negedge clk);
   endtask

   task automatic do_commit(input logic [31:0] a, input bit with_wr, input logic [7:0] idx,
                            input logic [31:0] d);
      int   n;
      logic tog;
      drive_commit(a, with_wr, idx, d, n, tog);
      model_commit(a, n, tog);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return RB_MIN;
         2:       return RB_MAX;
         3:       return RB_MIN - 32'd1;
         4:       return RB_MAX + 32'd1;
         5:       return 32'($urandom_range(100000, 199999));
         6:       return 32'($urandom_range(1, 99999));
         default: return 32'($urandom_range(200000, 900000));
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int   n, n2;
      logic tog, tog2, old_ack;
      model_reset();
      tick(3);
      check("reset_addr", config_addr, 32'd0);
      check("reset_valid", 32'(config_valid), 32'd0);
      check("reset_data_or", 32'(|config_data), 32'd0);
      check("reset_status", gpio_status, 32'd0);
      rstn = 1'b1;
      tick(2);

      // 1: data commit timing and content
      for (int k = 0; k < NW; k++) do_wr(8'(k), 32'h1000 + 32'(k));
      tick(1);
      old_ack = m_cm_ack;
      drive_commit(32'd5000, 1'b0, 8'd0, 32'd0, n, tog);
      model_commit(32'd5000, n, tog);
      tick(1);
      check("t1_valid", 32'(config_valid), 32'd1);
      check("t1_word3", config_data[3*32 +: 32], 32'h1003);
      tick(5);
      check("t1_ack_before", 32'(gpio_status[1]), 32'(old_ack));
      tick(1);
      check("t1_ack_at_n7", 32'(gpio_status[1]), 32'(tog));
      tick(2);

      // 2: readback hold
      drive_commit(32'd100001, 1'b0, 8'd0, 32'd0, n, tog);
      model_commit(32'd100001, n, tog);
      tick(1);
      check("t2_ack", 32'(gpio_status[1]), 32'(tog));
      tick(100);
      check("t2_addr_held", config_addr, 32'd100001);
      check("t2_valid", 32'(config_valid), 32'd0);

      // 3: busy overlap with pending and overrun
      drive_commit(32'd6000, 1'b0, 8'd0, 32'd0, n, tog);
      model_commit(32'd6000, n, tog);
      drive_commit(32'd7000, 1'b0, 8'd0, 32'd0, n2, tog2);
      drive_commit(32'd8000, 1'b0, 8'd0, 32'd0, n2, tog);
      model_commit(32'd7000, n + 7, tog2);
      m_ovr = 8'd1;
      tick(3);
      check("t3_pending", 32'(gpio_status[3]), 32'd1);
      check("t3_busy", 32'(gpio_status[2]), 32'd1);
      check("t3_overrun", 32'(gpio_status[15:8]), 32'd1);
      tick(4);
      check("t3_pending_clr", 32'(gpio_status[3]), 32'd0);
      tick(8);
      check("t3_status", gpio_status, m_status());

      // 4: boundary errors and error clear
      do_wr(8'd16, 32'hBAD0_0016);
      tick(2);
      check("t4_idx_err", gpio_status, m_status());
      do_commit(32'd0, 1'b0, 8'd0, 32'd0);
      tick(3);
      check("t4_addr0_err", gpio_status, m_status());
      do_clear();
      tick(2);
      check("t4_cleared", gpio_status, m_status());

      // 5: write and commit in the same cycle
      drive_commit(32'd9000, 1'b1, 8'd2, 32'h0000_DEAD, n, tog);
      model_commit(32'd9000, n, tog);
      tick(1);
      check("t5_word2", config_data[2*32 +: 32], 32'h0000_DEAD);
      tick(HOLD + GUARD + 2);
      check("t5_status", gpio_status, m_status());

      // randomized traffic, one operation at a time
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
               do_wr(8'($urandom_range(0, NW + 1)), $urandom);
               tick(2);
            end
            5, 6, 7: begin
               do_commit(pick_addr(), 1'b0, 8'd0, 32'd0);
               tick(HOLD + GUARD + 2);
            end
            8: begin
               do_commit(pick_addr(), 1'b1, 8'($urandom_range(0, NW - 1)), $urandom);
               tick(HOLD + GUARD + 2);
            end
            default: begin
               do_clear();
               tick(2);
            end
         endcase
         check("rand_status", gpio_status, m_status());
      end

      // 6: reset during HOLD
      drive_commit(32'd12345, 1'b0, 8'd0, 32'd0, n, tog);
      push_rec(n + 1, 32'd12345, 1'b1, snap());
      tick(1);
      rstn          = 1'b0;
      gpio_ctrl[31] = 1'b1;
      model_reset();
      push_rec(n + 2, 32'd0, 1'b0, '0);
      tick(1);
      check("t6_addr", config_addr, 32'd0);
      check("t6_valid", 32'(config_valid), 32'd0);
      tick(2);
      rstn = 1'b1;
      tick(3);
      check("t6_status", gpio_status, m_status());

      // fresh data commit after reset: shadow must be all zero except word 5
      do_wr(8'd5, 32'h5555_0005);
      tick(1);
      do_commit(32'd4242, 1'b0, 8'd0, 32'd0);
      tick(HOLD + GUARD + 4);
      check("post_reset_status", gpio_status, m_status());
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
